// File: rtl/encoder4to2_seq.sv
// ---------------------------------------------------------------------------
// encoder4to2_seq
//
// Sequential 4-to-2 priority encoder. Request pulses on four lines are
// latched into a pending register; the highest-priority pending line is
// presented as a 2-bit code on a registered valid/ready output port. The
// code can drive decoder2to4_struct to regenerate the one-hot line.
//
// Parameters:
//   HIGH_FIRST    1: bit 3 has highest priority, 0: bit 0 has highest priority
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous reset, active low
//   req_i         request pulses, any number may be high in a cycle
//   clr_overrun_i synchronous clear of the overrun flag
//   out_ready_i   consumer accepts out_code_o this cycle
//   out_valid_o   out_code_o holds a valid grant
//   out_code_o    binary index of the granted line
//   out_multi_o   other requests were still pending when this grant was taken
//   overrun_o     sticky: a request hit a line that was already pending
//   idle_o        nothing pending and no valid output
// ---------------------------------------------------------------------------
module encoder4to2_seq #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    input  logic       clr_overrun_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic [1:0] out_code_o,
    output logic       out_multi_o,
    output logic       overrun_o,
    output logic       idle_o
);

    logic [3:0] pending_q, pending_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_code_q, out_code_d;
    logic       out_multi_q, out_multi_d;
    logic       overrun_q, overrun_d;

    logic       load;
    logic       any_pending;
    logic       many_pending;
    logic [1:0] sel_idx;
    logic [3:0] grant_mask;
    logic       overrun_set;

    // The output register may take a new grant when empty or being drained.
    assign load         = !out_valid_q || out_ready_i;
    assign any_pending  = |pending_q;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign many_pending = |(pending_q & (pending_q - 4'd1));

    // Priority select on the registered pending vector only; the last match
    // in scan order wins, so scan from lowest to highest priority.
    always_comb begin
        sel_idx = 2'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 4; i++) begin
                if (pending_q[i]) begin
                    sel_idx = 2'(i);
                end
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (pending_q[i]) begin
                    sel_idx = 2'(i);
                end
            end
        end
    end

    assign grant_mask = (load && any_pending) ? (4'b0001 << sel_idx) : 4'b0000;

    // A request on the line being granted this cycle is re-queued, and does
    // not count as an overrun because the old request is leaving.
    assign pending_d   = (pending_q & ~grant_mask) | req_i;
    assign overrun_set = |(req_i & pending_q & ~grant_mask);

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_multi_d = out_multi_q;
        if (load) begin
            if (any_pending) begin
                out_valid_d = 1'b1;
                out_code_d  = sel_idx;
                out_multi_d = many_pending;
            end else begin
                // Code and multi keep their last values so the bus never goes X.
                out_valid_d = 1'b0;
            end
        end
    end

    // Set has priority over clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= 4'b0000;
            out_valid_q <= 1'b0;
            out_code_q  <= 2'b00;
            out_multi_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_multi_q <= out_multi_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_code_o  = out_code_q;
    assign out_multi_o = out_multi_q;
    assign overrun_o   = overrun_q;
    assign idle_o      = !any_pending && !out_valid_q;

endmodule

// File: tb/tb_encoder4to2_seq.sv
// ---------------------------------------------------------------------------
// tb_encoder4to2_seq
//
// Drives two encoder instances (HIGH_FIRST = 1 and 0) from shared inputs.
// Expected grants are queued when requests are driven and compared as each
// handshake completes. Inputs change and outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_encoder4to2_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       clr_overrun;
    logic       out_ready;

    logic       hi_valid, lo_valid;
    logic [1:0] hi_code, lo_code;
    logic       hi_multi, lo_multi;
    logic       hi_ovr, lo_ovr;
    logic       hi_idle, lo_idle;

    typedef struct packed {
        logic [1:0] hi_code;
        logic       hi_multi;
        logic [1:0] lo_code;
        logic       lo_multi;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;

    encoder4to2_seq #(.HIGH_FIRST(1'b1)) dut_hi (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .clr_overrun_i (clr_overrun),
        .out_ready_i   (out_ready),
        .out_valid_o   (hi_valid),
        .out_code_o    (hi_code),
        .out_multi_o   (hi_multi),
        .overrun_o     (hi_ovr),
        .idle_o        (hi_idle)
    );

    encoder4to2_seq #(.HIGH_FIRST(1'b0)) dut_lo (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .clr_overrun_i (clr_overrun),
        .out_ready_i   (out_ready),
        .out_valid_o   (lo_valid),
        .out_code_o    (lo_code),
        .out_multi_o   (lo_multi),
        .overrun_o     (lo_ovr),
        .idle_o        (lo_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req         = 4'b0000;
        clr_overrun = 1'b0;
        out_ready   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({hi_valid, hi_code, hi_multi, hi_ovr, hi_idle} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_hi: got v/code/m/ovr/idle=%b %b %b %b %b want 0 00 0 0 1",
                     hi_valid, hi_code, hi_multi, hi_ovr, hi_idle);
        end
        n_tests++;
        if ({lo_valid, lo_code, lo_multi, lo_ovr, lo_idle} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_lo: got v/code/m/ovr/idle=%b %b %b %b %b want 0 00 0 0 1",
                     lo_valid, lo_code, lo_multi, lo_ovr, lo_idle);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        req       = 4'b0100;
        tick();
        req = 4'b0000;
        n_tests++;
        if (hi_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: out_valid=%b want 0 one cycle after req", hi_valid);
        end
        tick();
        n_tests++;
        if ({hi_valid, hi_code, hi_multi} !== 4'b1100 ||
            {lo_valid, lo_code, lo_multi} !== 4'b1100) begin
            n_fail++;
            $display("FAIL single_grant: hi=%b%b%b lo=%b%b%b want v=1 code=10 m=0",
                     hi_valid, hi_code, hi_multi, lo_valid, lo_code, lo_multi);
        end
        tick();
        n_tests++;
        if ({hi_valid, hi_idle, lo_valid, lo_idle} !== 4'b0101) begin
            n_fail++;
            $display("FAIL single_after: hi v/idle=%b%b lo v/idle=%b%b want 01 01",
                     hi_valid, hi_idle, lo_valid, lo_idle);
        end
    endtask

    // Scoreboard drain: pop one entry per completed handshake until empty.
    task automatic test_priority();
        out_ready = 1'b1;
        req       = 4'b1011;
        exp_q.push_back('{hi_code: 2'd3, hi_multi: 1'b1, lo_code: 2'd0, lo_multi: 1'b1});
        exp_q.push_back('{hi_code: 2'd1, hi_multi: 1'b1, lo_code: 2'd1, lo_multi: 1'b1});
        exp_q.push_back('{hi_code: 2'd0, hi_multi: 1'b0, lo_code: 2'd3, lo_multi: 1'b0});
        tick();
        req = 4'b0000;
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            tick();
            if (hi_valid === 1'b1 && out_ready === 1'b1) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({hi_code, hi_multi, lo_valid, lo_code, lo_multi} !==
                    {e.hi_code, e.hi_multi, 1'b1, e.lo_code, e.lo_multi}) begin
                    n_fail++;
                    $display("FAIL priority_grant: hi=%b/%b lo=%b %b/%b want hi=%b/%b lo=1 %b/%b",
                             hi_code, hi_multi, lo_valid, lo_code, lo_multi,
                             e.hi_code, e.hi_multi, e.lo_code, e.lo_multi);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL priority_count: %0d grants missing, want 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        n_tests++;
        if (hi_idle !== 1'b1 || lo_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_idle: idle hi=%b lo=%b want 1", hi_idle, lo_idle);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req       = 4'b0001;
        tick();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        exp_q.push_back('{hi_code: 2'd0, hi_multi: 1'b0, lo_code: 2'd0, lo_multi: 1'b0});
        exp_q.push_back('{hi_code: 2'd3, hi_multi: 1'b0, lo_code: 2'd3, lo_multi: 1'b0});
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({hi_valid, hi_code, lo_valid, lo_code} !== 6'b100100) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d hi=%b %b lo=%b %b want 1 00 1 00",
                         c, hi_valid, hi_code, lo_valid, lo_code);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
            if (hi_valid === 1'b1 && out_ready === 1'b1) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({hi_code, hi_multi, lo_valid, lo_code, lo_multi} !==
                    {e.hi_code, e.hi_multi, 1'b1, e.lo_code, e.lo_multi}) begin
                    n_fail++;
                    $display("FAIL bp_grant: hi=%b/%b lo=%b %b/%b want hi=%b/%b lo=1 %b/%b",
                             hi_code, hi_multi, lo_valid, lo_code, lo_multi,
                             e.hi_code, e.hi_multi, e.lo_code, e.lo_multi);
                end
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0 || hi_valid !== 1'b0 || lo_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: left=%0d valid hi=%b lo=%b want 0 0 0",
                     exp_q.size(), hi_valid, lo_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        req       = 4'b0001;
        tick();
        req = 4'b0000;
        tick();                   // output now holds code 00
        req = 4'b0010;
        tick();                   // pending = 0010
        req = 4'b0000;
        tick();
        n_tests++;
        if (hi_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_early: overrun=%b want 0", hi_ovr);
        end
        req = 4'b0010;
        tick();
        req = 4'b0000;
        n_tests++;
        if (hi_ovr !== 1'b1 || lo_ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: overrun hi=%b lo=%b want 1", hi_ovr, lo_ovr);
        end
        // Clear and a fresh overrun in the same cycle: set wins.
        clr_overrun = 1'b1;
        req         = 4'b0010;
        tick();
        req = 4'b0000;
        n_tests++;
        if (hi_ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins: overrun=%b want 1", hi_ovr);
        end
        tick();
        clr_overrun = 1'b0;
        n_tests++;
        if (hi_ovr !== 1'b0 || lo_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: overrun hi=%b lo=%b want 0", hi_ovr, lo_ovr);
        end
        // Merged requests give exactly one grant of 01 behind the held 00.
        exp_q.push_back('{hi_code: 2'd0, hi_multi: 1'b0, lo_code: 2'd0, lo_multi: 1'b0});
        exp_q.push_back('{hi_code: 2'd1, hi_multi: 1'b0, lo_code: 2'd1, lo_multi: 1'b0});
        out_ready = 1'b1;
        for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
            if (hi_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({hi_code, lo_code} !== {e.hi_code, e.lo_code}) begin
                    n_fail++;
                    $display("FAIL ovr_drain_code: hi=%b lo=%b want %b %b",
                             hi_code, lo_code, e.hi_code, e.lo_code);
                end
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0 || hi_valid !== 1'b0 || hi_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_drain_end: left=%0d valid=%b idle=%b want 0 0 1",
                     exp_q.size(), hi_valid, hi_idle);
            exp_q.delete();
        end
    endtask

    task automatic test_rerequest();
        out_ready = 1'b1;
        req       = 4'b0010;
        tick();                   // pending = 0010
        req = 4'b0010;            // re-request in the cycle the grant is taken
        exp_q.push_back('{hi_code: 2'd1, hi_multi: 1'b0, lo_code: 2'd1, lo_multi: 1'b0});
        exp_q.push_back('{hi_code: 2'd1, hi_multi: 1'b0, lo_code: 2'd1, lo_multi: 1'b0});
        tick();
        req = 4'b0000;
        for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
            if (hi_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({hi_code, hi_multi, hi_ovr} !== {e.hi_code, e.hi_multi, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rereq_grant: code/m/ovr=%b/%b/%b want %b/%b/0",
                             hi_code, hi_multi, hi_ovr, e.hi_code, e.hi_multi);
                end
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0 || hi_ovr !== 1'b0 || hi_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rereq_end: left=%0d ovr=%b valid=%b want 0 0 0",
                     exp_q.size(), hi_ovr, hi_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        req       = 4'b0001;
        tick();
        req = 4'b1110;
        tick();                   // output holds 00, pending = 1110
        req = 4'b0000;
        tick();
        n_tests++;
        if (hi_valid !== 1'b1 || hi_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_setup: valid=%b idle=%b want 1 0", hi_valid, hi_idle);
        end
        #2;                       // between edges
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({hi_valid, hi_code, hi_multi, hi_ovr, hi_idle} !== 6'b000001 ||
            {lo_valid, lo_code, lo_multi, lo_ovr, lo_idle} !== 6'b000001) begin
            n_fail++;
            $display("FAIL arst_immediate: hi=%b%b%b%b%b lo=%b%b%b%b%b want 000001",
                     hi_valid, hi_code, hi_multi, hi_ovr, hi_idle,
                     lo_valid, lo_code, lo_multi, lo_ovr, lo_idle);
        end
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (hi_valid !== 1'b0 || lo_valid !== 1'b0 || hi_idle !== 1'b1) begin
                n_fail++;
                $display("FAIL arst_no_grant: cycle %0d valid hi=%b lo=%b idle=%b want 0 0 1",
                         c, hi_valid, lo_valid, hi_idle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_overrun();
        test_rerequest();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
